// File: rtl/scr1_pipe_sram_bridge_pkg.sv
// Shared memory-interface types, bridge FSM states and SRAM geometry.
package scr1_pipe_sram_bridge_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_IDLE   = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        BRIDGE_IDLE  = 2'b00,
        BRIDGE_ACC   = 2'b01,
        BRIDGE_MERGE = 2'b10,
        BRIDGE_RESP  = 2'b11
    } bridge_state_e;

    localparam int SRAM_DEPTH = 1024;

    // True when the byte offset is not naturally aligned for the access width.
    function automatic logic is_misaligned(input type_scr1_mem_width_e width,
                                           input logic [1:0] byte_off);
        case (width)
            SCR1_MEM_WIDTH_BYTE:  is_misaligned = 1'b0;
            SCR1_MEM_WIDTH_HWORD: is_misaligned = byte_off[0];
            SCR1_MEM_WIDTH_WORD:  is_misaligned = (byte_off != 2'b00);
            default:              is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/scr1_sram_lane_merge.sv
// Byte-lane merge for partial stores and right-alignment of read data.
module scr1_sram_lane_merge
    import scr1_pipe_sram_bridge_pkg::*;
(
    input  logic [31:0]          old_word,
    input  logic [31:0]          wdata,
    input  type_scr1_mem_width_e width,
    input  logic [1:0]           byte_off,
    output logic [31:0]          merged,
    output logic [31:0]          shifted
);

    logic [4:0]  shamt;
    logic [31:0] wdata_sh;

    assign shamt    = {byte_off, 3'b000};
    assign wdata_sh = wdata << shamt;
    assign shifted  = old_word >> shamt;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_sel;
            // Select which byte lanes take new data for this access width.
            always_comb begin
                lane_sel = 1'b0;
                case (width)
                    SCR1_MEM_WIDTH_BYTE:  lane_sel = (byte_off == gi[1:0]);
                    SCR1_MEM_WIDTH_HWORD: lane_sel = (byte_off[1] == gi[1]);
                    SCR1_MEM_WIDTH_WORD:  lane_sel = 1'b1;
                    default:              lane_sel = 1'b0;
                endcase
            end
            assign merged[8*gi +: 8] = lane_sel ? wdata_sh[8*gi +: 8] : old_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/scr1_pipe_sram_bridge.sv
// Arbitrates IMEM and DMEM requests onto one single-port SRAM; partial stores use read-modify-write.
module scr1_pipe_sram_bridge
    import scr1_pipe_sram_bridge_pkg::*;
#(
    parameter int          SRAM_AWIDTH = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   imem_req_i,
    input  type_scr1_mem_cmd_e     imem_cmd_i,
    input  logic [31:0]            imem_addr_i,
    output logic                   imem_req_ack_o,
    output logic [31:0]            imem_rdata_o,
    output type_scr1_mem_resp_e    imem_resp_o,
    input  logic                   dmem_req_i,
    input  type_scr1_mem_cmd_e     dmem_cmd_i,
    input  type_scr1_mem_width_e   dmem_width_i,
    input  logic [31:0]            dmem_addr_i,
    input  logic [31:0]            dmem_wdata_i,
    output logic                   dmem_req_ack_o,
    output logic [31:0]            dmem_rdata_o,
    output type_scr1_mem_resp_e    dmem_resp_o,
    output logic                   sram_csb0_o,
    output logic                   sram_web0_o,
    output logic [SRAM_AWIDTH-1:0] sram_addr0_o,
    output logic [31:0]            sram_din0_o,
    input  logic [31:0]            sram_dout0_i
);

    bridge_state_e          state_reg, state_next;
    logic                   owner_dmem_reg;
    logic                   last_dmem_reg;
    type_scr1_mem_cmd_e     cmd_reg;
    type_scr1_mem_width_e   width_reg;
    logic [SRAM_AWIDTH+1:0] addr_reg;
    logic [31:0]            wdata_reg;
    logic                   err_reg;

    logic                   grant_imem, grant_dmem, accept;
    type_scr1_mem_cmd_e     sel_cmd;
    type_scr1_mem_width_e   sel_width;
    logic [31:0]            sel_addr, sel_wdata;
    logic                   sel_err, in_window, partial_wr;
    logic [31:0]            merged_word, shifted_word;
    type_scr1_mem_resp_e    resp_code;
    logic [31:0]            resp_rdata;

    // Round-robin: on contention the port not granted last wins.
    assign grant_imem = (state_reg == BRIDGE_IDLE) & imem_req_i & (~dmem_req_i | last_dmem_reg);
    assign grant_dmem = (state_reg == BRIDGE_IDLE) & dmem_req_i & ~grant_imem;
    assign accept     = grant_imem | grant_dmem;
    assign imem_req_ack_o = grant_imem;
    assign dmem_req_ack_o = grant_dmem;

    // IMEM fetches are always full words and never carry write data.
    assign sel_cmd   = grant_dmem ? dmem_cmd_i   : imem_cmd_i;
    assign sel_width = grant_dmem ? dmem_width_i : SCR1_MEM_WIDTH_WORD;
    assign sel_addr  = grant_dmem ? dmem_addr_i  : imem_addr_i;
    assign sel_wdata = grant_dmem ? dmem_wdata_i : 32'h0;

    assign in_window = (sel_addr[31:SRAM_AWIDTH+2] == BASE_ADDR[31:SRAM_AWIDTH+2]);
    assign sel_err   = ~in_window
                     | is_misaligned(sel_width, sel_addr[1:0])
                     | (grant_imem & (sel_cmd == SCR1_MEM_CMD_WR));

    assign partial_wr = (cmd_reg == SCR1_MEM_CMD_WR) & (width_reg != SCR1_MEM_WIDTH_WORD);

    scr1_sram_lane_merge u_lane_merge (
        .old_word (sram_dout0_i),
        .wdata    (wdata_reg),
        .width    (width_reg),
        .byte_off (addr_reg[1:0]),
        .merged   (merged_word),
        .shifted  (shifted_word)
    );

    // State register and latched copy of the accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= BRIDGE_IDLE;
            owner_dmem_reg <= 1'b0;
            last_dmem_reg  <= 1'b0;
            cmd_reg        <= SCR1_MEM_CMD_RD;
            width_reg      <= SCR1_MEM_WIDTH_WORD;
            addr_reg       <= '0;
            wdata_reg      <= 32'h0;
            err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_dmem_reg <= grant_dmem;
                last_dmem_reg  <= grant_dmem;
                cmd_reg        <= sel_cmd;
                width_reg      <= sel_width;
                addr_reg       <= sel_addr[SRAM_AWIDTH+1:0];
                wdata_reg      <= sel_wdata;
                err_reg        <= sel_err;
            end
        end
    end

    // Next-state logic; decode errors skip the SRAM entirely.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BRIDGE_IDLE:  if (accept) state_next = sel_err ? BRIDGE_RESP : BRIDGE_ACC;
            BRIDGE_ACC:   state_next = partial_wr ? BRIDGE_MERGE : BRIDGE_RESP;
            BRIDGE_MERGE: state_next = BRIDGE_RESP;
            BRIDGE_RESP:  state_next = BRIDGE_IDLE;
            default:      state_next = BRIDGE_IDLE;
        endcase
    end

    // SRAM drive; the macro shares clk, so rst masks the access to keep an aborted write from landing.
    always_comb begin
        sram_csb0_o  = 1'b1;
        sram_web0_o  = 1'b1;
        sram_addr0_o = '0;
        sram_din0_o  = 32'h0;
        if (!rst) begin
            case (state_reg)
                BRIDGE_ACC: begin
                    sram_csb0_o  = 1'b0;
                    sram_addr0_o = addr_reg[SRAM_AWIDTH+1:2];
                    if (!partial_wr) begin
                        sram_web0_o = ~(cmd_reg == SCR1_MEM_CMD_WR);
                        sram_din0_o = wdata_reg;
                    end
                end
                BRIDGE_MERGE: begin
                    sram_csb0_o  = 1'b0;
                    sram_web0_o  = 1'b0;
                    sram_addr0_o = addr_reg[SRAM_AWIDTH+1:2];
                    sram_din0_o  = merged_word;
                end
                default: ;
            endcase
        end
    end

    // One-cycle response steered to the owner only; rdata is zero unless a successful read.
    always_comb begin
        resp_code    = err_reg ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        resp_rdata   = (!err_reg && cmd_reg == SCR1_MEM_CMD_RD) ? shifted_word : 32'h0;
        imem_resp_o  = SCR1_MEM_RESP_IDLE;
        imem_rdata_o = 32'h0;
        dmem_resp_o  = SCR1_MEM_RESP_IDLE;
        dmem_rdata_o = 32'h0;
        if (state_reg == BRIDGE_RESP) begin
            if (owner_dmem_reg) begin
                dmem_resp_o  = resp_code;
                dmem_rdata_o = resp_rdata;
            end else begin
                imem_resp_o  = resp_code;
                imem_rdata_o = resp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_scr1_pipe_sram_bridge.sv
// Directed bench: vector table for single transactions plus arbitration, reset-abort and streaming sequences.
module tb_scr1_pipe_sram_bridge;
    import scr1_pipe_sram_bridge_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 imem_req = 1'b0;
    type_scr1_mem_cmd_e   imem_cmd = SCR1_MEM_CMD_RD;
    logic [31:0]          imem_addr = 32'h0;
    logic                 imem_req_ack;
    logic [31:0]          imem_rdata;
    type_scr1_mem_resp_e  imem_resp;
    logic                 dmem_req = 1'b0;
    type_scr1_mem_cmd_e   dmem_cmd = SCR1_MEM_CMD_RD;
    type_scr1_mem_width_e dmem_width = SCR1_MEM_WIDTH_WORD;
    logic [31:0]          dmem_addr = 32'h0;
    logic [31:0]          dmem_wdata = 32'h0;
    logic                 dmem_req_ack;
    logic [31:0]          dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;
    logic                 sram_csb0, sram_web0;
    logic [9:0]           sram_addr0;
    logic [31:0]          sram_din0;
    logic [31:0]          sram_dout0 = 32'h0;
    logic [31:0]          sram_mem [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scr1_pipe_sram_bridge #(.SRAM_AWIDTH(10), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_i(imem_req), .imem_cmd_i(imem_cmd), .imem_addr_i(imem_addr),
        .imem_req_ack_o(imem_req_ack), .imem_rdata_o(imem_rdata), .imem_resp_o(imem_resp),
        .dmem_req_i(dmem_req), .dmem_cmd_i(dmem_cmd), .dmem_width_i(dmem_width),
        .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata),
        .dmem_req_ack_o(dmem_req_ack), .dmem_rdata_o(dmem_rdata), .dmem_resp_o(dmem_resp),
        .sram_csb0_o(sram_csb0), .sram_web0_o(sram_web0), .sram_addr0_o(sram_addr0),
        .sram_din0_o(sram_din0), .sram_dout0_i(sram_dout0)
    );

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) sram_mem[sram_addr0] <= sram_din0;
            else            sram_dout0 <= sram_mem[sram_addr0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic                 is_d;
        type_scr1_mem_cmd_e   cmd;
        type_scr1_mem_width_e width;
        logic [31:0]          addr;
        logic [31:0]          wdata;
        type_scr1_mem_resp_e  resp;
        logic [31:0]          rdata;
        int                   lat;
    } vec_t;

    function automatic vec_t mk(input logic is_d, input type_scr1_mem_cmd_e cmd,
                                input type_scr1_mem_width_e width, input logic [31:0] addr,
                                input logic [31:0] wdata, input type_scr1_mem_resp_e resp,
                                input logic [31:0] rdata, input int lat);
        vec_t v;
        v.is_d = is_d; v.cmd = cmd; v.width = width; v.addr = addr;
        v.wdata = wdata; v.resp = resp; v.rdata = rdata; v.lat = lat;
        return v;
    endfunction

    // Issue one transaction, then measure latency, response, data and SRAM activity.
    task automatic do_txn(input string name, input vec_t v);
        type_scr1_mem_resp_e r, ro;
        logic [31:0] rd;
        logic got = 1'b0;
        logic csb_seen = 1'b0;
        int lat = 0;
        @(negedge clk);
        if (v.is_d) begin
            dmem_req = 1'b1; dmem_cmd = v.cmd; dmem_width = v.width;
            dmem_addr = v.addr; dmem_wdata = v.wdata;
        end else begin
            imem_req = 1'b1; imem_cmd = v.cmd; imem_addr = v.addr;
        end
        #1;
        check({name, " ack"}, v.is_d ? dmem_req_ack : imem_req_ack, 1);
        check({name, " other_ack"}, v.is_d ? imem_req_ack : dmem_req_ack, 0);
        @(negedge clk);
        imem_req = 1'b0; dmem_req = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            if (!sram_csb0) csb_seen = 1'b1;
            r  = v.is_d ? dmem_resp : imem_resp;
            ro = v.is_d ? imem_resp : dmem_resp;
            rd = v.is_d ? dmem_rdata : imem_rdata;
            if (r != SCR1_MEM_RESP_IDLE) begin
                got = 1'b1; lat = k;
                check({name, " resp"}, r, v.resp);
                check({name, " rdata"}, rd, v.rdata);
                check({name, " other_resp"}, ro, SCR1_MEM_RESP_IDLE);
            end
        end
        check({name, " responded"}, got, 1);
        check({name, " latency"}, lat, v.lat);
        if (v.resp == SCR1_MEM_RESP_RDY_ER) check({name, " no_sram_access"}, csb_seen, 0);
        @(negedge clk); #1;
        check({name, " resp_one_cycle"}, v.is_d ? dmem_resp : imem_resp, SCR1_MEM_RESP_IDLE);
        $display("txn %s port=%s addr=%08h resp=%0d rdata=%08h lat=%0d",
                 name, v.is_d ? "D" : "I", v.addr, r, rd, lat);
    endtask

    vec_t vecs[19];

    initial begin
        int n_ack, n_resp, last_ack;
        logic grant_q [6];
        logic [31:0] stream_exp [3];

        vecs[0]  = mk(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h10,   32'hDEADBEEF, SCR1_MEM_RESP_RDY_OK, 32'h0, 2);
        vecs[1]  = mk(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h10,   32'h0, SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF, 2);
        vecs[2]  = mk(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h20,   32'h11223344, SCR1_MEM_RESP_RDY_OK, 32'h0, 2);
        vecs[3]  = mk(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'h21,   32'h000000AA, SCR1_MEM_RESP_RDY_OK, 32'h0, 3);
        vecs[4]  = mk(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h20,   32'h0, SCR1_MEM_RESP_RDY_OK, 32'h1122AA44, 2);
        vecs[5]  = mk(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h23,   32'h0, SCR1_MEM_RESP_RDY_OK, 32'h00000011, 2);
        vecs[6]  = mk(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h22,   32'h00005566, SCR1_MEM_RESP_RDY_OK, 32'h0, 3);
        vecs[7]  = mk(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h20,   32'h0, SCR1_MEM_RESP_RDY_OK, 32'h5566AA44, 2);
        vecs[8]  = mk(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h22,   32'h0, SCR1_MEM_RESP_RDY_OK, 32'h00005566, 2);
        vecs[9]  = mk(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h01,   32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0, 1);
        vecs[10] = mk(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h02,   32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0, 1);
        vecs[11] = mk(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h1000, 32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0, 1);
        vecs[12] = mk(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h00,   32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0, 1);
        vecs[13] = mk(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h13,   32'h1234, SCR1_MEM_RESP_RDY_ER, 32'h0, 1);
        vecs[14] = mk(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h00,   32'hA0A0A0A0, SCR1_MEM_RESP_RDY_OK, 32'h0, 2);
        vecs[15] = mk(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h04,   32'hB1B1B1B1, SCR1_MEM_RESP_RDY_OK, 32'h0, 2);
        vecs[16] = mk(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h08,   32'hC2C2C2C2, SCR1_MEM_RESP_RDY_OK, 32'h0, 2);
        vecs[17] = mk(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h04,   32'h0, SCR1_MEM_RESP_RDY_OK, 32'hB1B1B1B1, 2);
        vecs[18] = mk(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'hFFC,  32'h0BADF00D, SCR1_MEM_RESP_RDY_OK, 32'h0, 2);

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("rst imem_ack", imem_req_ack, 0);
        check("rst dmem_ack", dmem_req_ack, 0);
        check("rst imem_resp", imem_resp, SCR1_MEM_RESP_IDLE);
        check("rst dmem_resp", dmem_resp, SCR1_MEM_RESP_IDLE);
        check("rst imem_rdata", imem_rdata, 0);
        check("rst dmem_rdata", dmem_rdata, 0);
        check("rst csb0", sram_csb0, 1);
        check("rst web0", sram_web0, 1);
        check("rst addr0", {22'h0, sram_addr0}, 0);
        check("rst din0", sram_din0, 0);

        // Table-driven single transactions
        for (int i = 0; i < 19; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

        // Round-robin with both ports held on the same word
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        imem_req = 1'b1; imem_cmd = SCR1_MEM_CMD_RD; imem_addr = 32'h10;
        dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD; dmem_addr = 32'h10;
        n_ack = 0; n_resp = 0;
        for (int cyc = 0; cyc < 40 && n_resp < 6; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (n_ack == 6) begin imem_req = 1'b0; dmem_req = 1'b0; end
            #1;
            if ((imem_req_ack || dmem_req_ack) && n_ack < 6) begin
                check($sformatf("arb grant%0d dmem", n_ack), dmem_req_ack, (n_ack % 2 == 0) ? 1 : 0);
                check($sformatf("arb grant%0d imem", n_ack), imem_req_ack, (n_ack % 2 == 0) ? 0 : 1);
                grant_q[n_ack] = dmem_req_ack;
                $display("arb ack%0d to %s", n_ack, dmem_req_ack ? "DMEM" : "IMEM");
                n_ack++;
            end
            if ((imem_resp != SCR1_MEM_RESP_IDLE || dmem_resp != SCR1_MEM_RESP_IDLE) && n_resp < n_ack) begin
                if (grant_q[n_resp]) begin
                    check($sformatf("arb resp%0d dmem_resp", n_resp), dmem_resp, SCR1_MEM_RESP_RDY_OK);
                    check($sformatf("arb resp%0d dmem_rdata", n_resp), dmem_rdata, 32'hDEADBEEF);
                    check($sformatf("arb resp%0d imem_idle", n_resp), imem_resp, SCR1_MEM_RESP_IDLE);
                    check($sformatf("arb resp%0d imem_rdata0", n_resp), imem_rdata, 0);
                end else begin
                    check($sformatf("arb resp%0d imem_resp", n_resp), imem_resp, SCR1_MEM_RESP_RDY_OK);
                    check($sformatf("arb resp%0d imem_rdata", n_resp), imem_rdata, 32'hDEADBEEF);
                    check($sformatf("arb resp%0d dmem_idle", n_resp), dmem_resp, SCR1_MEM_RESP_IDLE);
                    check($sformatf("arb resp%0d dmem_rdata0", n_resp), dmem_rdata, 0);
                end
                n_resp++;
            end
        end
        imem_req = 1'b0; dmem_req = 1'b0;
        check("arb resp_count", n_resp, 6);

        // Reset during MERGE of a byte write must leave the word untouched
        do_txn("rmw_pre", mk(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h30, 32'h12345678,
                             SCR1_MEM_RESP_RDY_OK, 32'h0, 2));
        @(negedge clk);
        dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_WR; dmem_width = SCR1_MEM_WIDTH_BYTE;
        dmem_addr = 32'h31; dmem_wdata = 32'h000000FF;
        #1; check("abort ack", dmem_req_ack, 1);
        @(negedge clk); dmem_req = 1'b0;
        @(negedge clk); #1;
        check("abort merge_csb0", sram_csb0, 0);
        check("abort merge_web0", sram_web0, 0);
        rst = 1'b1;
        #1; check("abort rst_csb0", sram_csb0, 1);
        @(negedge clk); rst = 1'b0; #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("abort idle%0d csb0", k), sram_csb0, 1);
            check($sformatf("abort idle%0d dmem_resp", k), dmem_resp, SCR1_MEM_RESP_IDLE);
            check($sformatf("abort idle%0d imem_resp", k), imem_resp, SCR1_MEM_RESP_IDLE);
            @(negedge clk); #1;
        end
        $display("abort reset during merge, dmem_resp=%0d csb0=%0b", dmem_resp, sram_csb0);
        do_txn("abort_readback", mk(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h30, 32'h0,
                                    SCR1_MEM_RESP_RDY_OK, 32'h12345678, 2));

        // IMEM streaming reads: one ack every 3 cycles
        stream_exp[0] = 32'hA0A0A0A0;
        stream_exp[1] = 32'hB1B1B1B1;
        stream_exp[2] = 32'hC2C2C2C2;
        n_ack = 0; n_resp = 0; last_ack = 0;
        imem_cmd = SCR1_MEM_CMD_RD;
        for (int cyc = 0; cyc < 30 && n_resp < 3; cyc++) begin
            @(negedge clk);
            if (n_ack == 3) imem_req = 1'b0;
            else begin imem_req = 1'b1; imem_addr = n_ack * 4; end
            #1;
            if (imem_req && imem_req_ack) begin
                if (n_ack > 0) check($sformatf("stream ack%0d spacing", n_ack), cyc - last_ack, 3);
                last_ack = cyc;
                n_ack++;
            end
            if (imem_resp != SCR1_MEM_RESP_IDLE && n_resp < 3) begin
                check($sformatf("stream resp%0d", n_resp), imem_resp, SCR1_MEM_RESP_RDY_OK);
                check($sformatf("stream rdata%0d", n_resp), imem_rdata, stream_exp[n_resp]);
                $display("stream read%0d rdata=%08h", n_resp, imem_rdata);
                n_resp++;
            end
        end
        imem_req = 1'b0;
        check("stream resp_count", n_resp, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scr1_pipe_sram_bridge.md
Name: scr1_pipe_sram_bridge

Overview:
- Memory-side neighbour of the pipeline top.
- Consumes the pipe IMEM and DMEM request/response interfaces and arbitrates both onto one single-port 32x1024 SRAM macro (clk0/csb0/web0/addr0/din0/dout0).
- The macro has no write mask, so byte and halfword stores run a read-modify-write sequence.
- Returns responses using the codebase memory protocol: req/req_ack, then resp IDLE/RDY_OK/RDY_ER.

Parameters:
- SRAM_AWIDTH, 10, SRAM word-address width (1024 words).
- BASE_ADDR, 32'h0000_0000, byte base of the SRAM window. Must be aligned to 4*2^SRAM_AWIDTH.

Ports:
- clk  in  1  clock. Also drives the SRAM clk0.
- rst  in  1  synchronous, active-high reset.
- imem_req_i  in  1  IMEM request.
- imem_cmd_i  in  type_scr1_mem_cmd_e  IMEM command.
- imem_addr_i  in  32  IMEM byte address.
- imem_req_ack_o  out  1  IMEM request accepted.
- imem_rdata_o  out  32  IMEM read data.
- imem_resp_o  out  type_scr1_mem_resp_e  IMEM response.
- dmem_req_i  in  1  DMEM request.
- dmem_cmd_i  in  type_scr1_mem_cmd_e  DMEM command.
- dmem_width_i  in  type_scr1_mem_width_e  DMEM access width.
- dmem_addr_i  in  32  DMEM byte address.
- dmem_wdata_i  in  32  DMEM write data, unshifted (byte in [7:0], half in [15:0]).
- dmem_req_ack_o  out  1  DMEM request accepted.
- dmem_rdata_o  out  32  DMEM read data, right-aligned.
- dmem_resp_o  out  type_scr1_mem_resp_e  DMEM response.
- sram_csb0_o  out  1  SRAM chip select, active low.
- sram_web0_o  out  1  SRAM write enable, active low.
- sram_addr0_o  out  SRAM_AWIDTH  SRAM word address.
- sram_din0_o  out  32  SRAM write data.
- sram_dout0_i  in  32  SRAM read data, valid the cycle after a read access.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE. Outputs after reset:
  - req_acks = 0.
  - resps = IDLE.
  - rdata = 0.
  - csb0 = 1, web0 = 1.
  - addr0 = 0, din0 = 0.
  - Arbitration pointer = "last granted IMEM".
- Reset mid-operation discards the in-flight transaction: no response, SRAM deselected on the next cycle.
- Accept:
  - req_ack is combinational and asserted only in IDLE, for the granted requester.
  - In the accept cycle, latch owner, cmd, width, addr and wdata.
- Arbitration when both requests are high in IDLE: round-robin; grant the port not granted last. A single requester always wins.
- Decode errors:
  - Address outside [BASE_ADDR, BASE_ADDR + 4*2^SRAM_AWIDTH).
  - HWORD with addr[0]=1.
  - WORD with addr[1:0]!=0.
  - IMEM cmd=WRITE.
  - On any error: go to RESP with RDY_ER; no SRAM access occurs.
- States: IDLE, ACC, MERGE, RESP.
  - IDLE -> RESP on an error accept; IDLE -> ACC on any other accept.
  - ACC, read or WORD write: csb0=0, web0 = ~write, addr0 = addr[SRAM_AWIDTH+1:2], din0 = wdata. Then -> RESP.
  - ACC, BYTE/HWORD write: SRAM read (web0=1). Then -> MERGE.
  - MERGE: write sram_dout0_i with the addressed lane(s) replaced by wdata << 8*addr[1:0]. Then -> RESP.
  - RESP: the owner's resp is driven for exactly 1 cycle. Then -> IDLE.
    - Read: RDY_OK with rdata = sram_dout0_i >> 8*addr[1:0].
    - Write: RDY_OK.
    - Error: RDY_ER.
- Latency from the ack cycle T:
  - Error response at T+1.
  - Read and word write response at T+2.
  - Partial write response at T+3.
- No accept occurs in the RESP cycle. Peak throughput is 1 transaction per 3 cycles.
- Non-owner port: resp=IDLE and rdata=0 at all times. rdata=0 whenever resp != RDY_OK.
- SRAM is deselected (csb0=1, web0=1) in IDLE and RESP.
- Requests may drop before ack without effect. Inputs are ignored after ack; the latched copy is used.

Decomposition:
- Reuse the existing memory-interface package for type_scr1_mem_cmd_e, type_scr1_mem_width_e and type_scr1_mem_resp_e.
- Add the FSM state enum and SRAM_DEPTH constant to the same package.
- One sub-module: scr1_sram_lane_merge.
  - Combinational; inputs old word, wdata, width, addr[1:0].
  - Outputs the merged word.
  - Also used for the read right-shift.

Test Plan:
1. DMEM WORD write 0xDEADBEEF @0x10, then WORD read @0x10 -> ack, RDY_OK at T+2 for each; read returns 0xDEADBEEF.
2. Preload 0x11223344 @0x20, DMEM BYTE write 0xAA @0x21 -> write RDY_OK at T+3. Read @0x20 returns 0x1122AA44. BYTE read @0x23 returns 0x00000011.
3. IMEM and DMEM requests held continuously to the same word for 6 transactions -> grants alternate DMEM, IMEM, DMEM...; each resp appears only on its owner port.
4. Errors -> RDY_ER at T+1 and csb0 stays 1, for each of:
   - HWORD @0x01.
   - WORD @0x02.
   - Address BASE_ADDR+0x1000.
   - IMEM WRITE.
5. Assert rst during MERGE of a byte write -> next cycle IDLE, csb0=1, no resp. The target word is unchanged on read-back.
6. Single IMEM requester streaming reads @0x0, 0x4, 0x8 -> one ack every 3 cycles; rdata matches preload.
